// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FSM control unit for the multi-cycle RV32I datapath
//
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with ready handshakes to both
// memories, a bounded data-memory wait and illegal-instruction detection.
// Optional macro CTRL_TRAP_EN: illegal instruction / dmem timeout enter a sticky
// TRAP state instead of being skipped as a NOP.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_instruction                IR contents, stable from DECODE onward
//   i_imem_ready, i_dmem_ready   memory ready (same-cycle response allowed)
//   i_br_taken                   branch comparator result
//   o_imem_read_en, o_ir_load    fetch request, IR load
//   o_pc_write, o_pc_sel         PC update, 0=PC+4 1=ALU result
//   o_sel_a_pc, o_sel_bw_imm_rs2 ALU operand selects
//   o_alu_op                     ALU operation
//   o_regfile_write_enable       register write
//   o_wr_back_sel                00=memory 01=ALU 10=PC+4
//   o_dmem_read_en/write_en      data memory requests
//   o_illegal_instr, o_mem_timeout  event flags
//   o_state                      FSM state (debug)
module multicycle_controller #(
    parameter int INSTR_WIDTH  = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [INSTR_WIDTH-1:0]  i_instruction,
    input  logic                    i_imem_ready,
    input  logic                    i_dmem_ready,
    input  logic                    i_br_taken,
    output logic                    o_imem_read_en,
    output logic                    o_ir_load,
    output logic                    o_pc_write,
    output logic                    o_pc_sel,
    output logic                    o_sel_a_pc,
    output logic                    o_sel_bw_imm_rs2,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic                    o_regfile_write_enable,
    output logic [1:0]              o_wr_back_sel,
    output logic                    o_dmem_read_en,
    output logic                    o_dmem_write_en,
    output logic                    o_illegal_instr,
    output logic                    o_mem_timeout,
    output logic [2:0]              o_state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(9);

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;

    logic [6:0] w_opcode, w_f7;
    logic [2:0] w_f3;
    logic       w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_is_jal;
    logic       w_illegal, w_to_hit, w_unused;
    logic [ALU_OP_WIDTH-1:0] w_alu_func;

    logic                    w_imem_read_en, w_ir_load, w_pc_write, w_pc_sel;
    logic                    w_sel_a_pc, w_sel_b, w_rf_we, w_dmem_rd, w_dmem_wr;
    logic                    w_illegal_instr, w_mem_timeout;
    logic [ALU_OP_WIDTH-1:0] w_alu_op;
    logic [1:0]              w_wb_sel;

    assign w_opcode = i_instruction[6:0];
    assign w_f3     = i_instruction[14:12];
    assign w_f7     = i_instruction[31:25];
    assign w_unused = ^{i_instruction[24:15], i_instruction[11:7]};

    assign w_is_r   = (w_opcode == 7'b0110011);
    assign w_is_i   = (w_opcode == 7'b0010011);
    assign w_is_ld  = (w_opcode == 7'b0000011);
    assign w_is_st  = (w_opcode == 7'b0100011);
    assign w_is_br  = (w_opcode == 7'b1100011);
    assign w_is_jal = (w_opcode == 7'b1101111);

    assign w_illegal = !( (w_is_r && ((w_f7 == 7'b0000000) ||
                                      (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101))))
                        || w_is_i
                        || (w_is_ld && !(w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111))
                        || (w_is_st && (w_f3 <= 3'b010))
                        || (w_is_br && !(w_f3 == 3'b010 || w_f3 == 3'b011))
                        || w_is_jal );

    // Timeout fires only when the counter has reached the limit and ready is
    // still low; a ready in the same cycle completes the access instead.
    assign w_to_hit = (MEM_TIMEOUT != 0) && (r_state == S_MEMORY) &&
                      !i_dmem_ready && (r_cnt == TO_VAL);

    // Bit 30 distinguishes sub/sra for R-type and srai for I-type; addi must
    // ignore it because there it is an immediate bit.
    always_comb begin
        w_alu_func = ALU_ADD;
        case (w_f3)
            3'b000:  w_alu_func = (w_is_r && i_instruction[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_func = ALU_SLL;
            3'b010:  w_alu_func = ALU_SLT;
            3'b011:  w_alu_func = ALU_SLTU;
            3'b100:  w_alu_func = ALU_XOR;
            3'b101:  w_alu_func = i_instruction[30] ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_func = ALU_OR;
            default: w_alu_func = ALU_AND;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (r_state == S_EXECUTE)
            r_cnt <= '0;
        else if (r_state == S_MEMORY && !i_dmem_ready && r_cnt != TO_VAL)
            r_cnt <= r_cnt + CW'(1);
    end

`ifdef CTRL_TRAP_EN
    // Remembers why TRAP was entered so the right flag is held.
    logic r_trap_to;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_trap_to <= 1'b0;
        else if (w_to_hit) r_trap_to <= 1'b1;
    end
`endif

    always_comb begin
        w_next          = r_state;
        w_imem_read_en  = 1'b0;
        w_ir_load       = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_sel        = 1'b0;
        w_sel_a_pc      = 1'b0;
        w_sel_b         = 1'b0;
        w_alu_op        = ALU_ADD;
        w_rf_we         = 1'b0;
        w_wb_sel        = 2'b00;
        w_dmem_rd       = 1'b0;
        w_dmem_wr       = 1'b0;
        w_illegal_instr = 1'b0;
        w_mem_timeout   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_read_en = 1'b1;
                if (i_imem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_illegal_instr = 1'b1;
`ifdef CTRL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
`endif
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (w_is_r || w_is_i) begin
                    w_alu_op = w_alu_func;
                    w_sel_b  = w_is_r;
                    w_next   = S_WRITEBACK;
                end else if (w_is_ld || w_is_st) begin
                    w_next = S_MEMORY;
                end else if (w_is_br) begin
                    w_sel_a_pc = 1'b1;
                    w_pc_write = 1'b1;
                    w_pc_sel   = i_br_taken;
                    w_next     = S_FETCH;
                end else begin
                    w_sel_a_pc = 1'b1;
                    w_next     = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                w_dmem_rd = w_is_ld;
                w_dmem_wr = w_is_st;
                if (i_dmem_ready) begin
                    if (w_is_ld) begin
                        w_next = S_WRITEBACK;
                    end else begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end
                end else if (w_to_hit) begin
                    w_mem_timeout = 1'b1;
`ifdef CTRL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
`endif
                end
            end
            S_WRITEBACK: begin
                w_rf_we    = 1'b1;
                w_pc_write = 1'b1;
                w_pc_sel   = w_is_jal;
                w_wb_sel   = w_is_ld ? 2'b00 : (w_is_jal ? 2'b10 : 2'b01);
                w_next     = S_FETCH;
            end
`ifdef CTRL_TRAP_EN
            S_TRAP: begin
                w_illegal_instr = !r_trap_to;
                w_mem_timeout   = r_trap_to;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Reset forces every control output low immediately, even mid-instruction.
    assign o_imem_read_en         = w_imem_read_en  & ~i_rst;
    assign o_ir_load              = w_ir_load       & ~i_rst;
    assign o_pc_write             = w_pc_write      & ~i_rst;
    assign o_pc_sel               = w_pc_sel        & ~i_rst;
    assign o_sel_a_pc             = w_sel_a_pc      & ~i_rst;
    assign o_sel_bw_imm_rs2       = w_sel_b         & ~i_rst;
    assign o_alu_op               = i_rst ? '0 : w_alu_op;
    assign o_regfile_write_enable = w_rf_we         & ~i_rst;
    assign o_wr_back_sel          = i_rst ? 2'b00 : w_wb_sel;
    assign o_dmem_read_en         = w_dmem_rd       & ~i_rst;
    assign o_dmem_write_en        = w_dmem_wr       & ~i_rst;
    assign o_illegal_instr        = w_illegal_instr & ~i_rst;
    assign o_mem_timeout          = w_mem_timeout   & ~i_rst;
    assign o_state                = r_state;

endmodule
